// File: rtl/core_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// core_seq_ctrl : multi-cycle FETCH/DECODE/MEM/WB sequencer with timeout trap
// Revision: 1.0
// ---------------------------------------------------------------------------
module core_seq_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        ifu_req,
  output logic [31:0] ifu_addr,
  input  logic        ifu_rvalid,
  input  logic [31:0] ifu_rdata,
  output logic        lsu_req,
  output logic        lsu_wen,
  input  logic        lsu_ready,
  output logic [31:0] instr,
  output logic [2:0]  imm_src,
  output logic        reg_we,
  output logic        pc_we,
  output logic        halted,
  output logic        trap
);

  localparam logic [2:0] I_TYPE = 3'd0;
  localparam logic [2:0] S_TYPE = 3'd1;
  localparam logic [2:0] B_TYPE = 3'd2;
  localparam logic [2:0] U_TYPE = 3'd3;
  localparam logic [2:0] J_TYPE = 3'd4;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM    = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       opcode;
  logic             illegal;
  logic             is_load;
  logic             is_store;
  logic             is_branch;
  logic             is_system;
  logic             cnt_last;

  assign opcode    = instr[6:0];
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_system = (opcode == OP_SYSTEM);
  assign cnt_last  = (cnt == CNT_W'(TIMEOUT - 1));

  // Request is masked by rst so it stays low for the whole reset cycle.
  assign ifu_req  = (state == S_FETCH) && !rst;
  assign ifu_addr = ifu_req ? pc_in : 32'h0;

  always_comb begin
    imm_src = I_TYPE;
    illegal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC: imm_src = U_TYPE;
      OP_JAL:           imm_src = J_TYPE;
      OP_BRANCH:        imm_src = B_TYPE;
      OP_STORE:         imm_src = S_TYPE;
      OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM, OP_REG: imm_src = I_TYPE;
      default:          illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      instr   <= NOP_INSTR;
      cnt     <= '0;
      reg_we  <= 1'b0;
      pc_we   <= 1'b0;
      lsu_req <= 1'b0;
      lsu_wen <= 1'b0;
      halted  <= 1'b0;
      trap    <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      pc_we  <= 1'b0;
      case (state)
        S_FETCH: begin
          if (ifu_rvalid) begin
            instr <= ifu_rdata;
            cnt   <= '0;
            state <= S_DECODE;
          end else if (cnt_last) begin
            cnt   <= '0;
            trap  <= 1'b1;
            state <= S_TRAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DECODE: begin
          cnt <= '0;
          if (illegal) begin
            trap  <= 1'b1;
            state <= S_TRAP;
          end else if (instr == EBREAK_INSTR) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else if (is_load || is_store) begin
            lsu_req <= 1'b1;
            lsu_wen <= is_store;
            state   <= S_MEM;
          end else begin
            pc_we  <= 1'b1;
            // Non-ebreak SYSTEM ops are executed as nops.
            reg_we <= !(is_branch || is_system);
            state  <= S_WB;
          end
        end
        S_MEM: begin
          if (lsu_ready) begin
            lsu_req <= 1'b0;
            lsu_wen <= 1'b0;
            pc_we   <= 1'b1;
            reg_we  <= is_load;
            state   <= S_WB;
          end else if (cnt_last) begin
            lsu_req <= 1'b0;
            lsu_wen <= 1'b0;
            cnt     <= '0;
            trap    <= 1'b1;
            state   <= S_TRAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WB: begin
          state <= S_FETCH;
        end
        S_HALT, S_TRAP: begin
          state <= state;
        end
        default: begin
          trap  <= 1'b1;
          state <= S_TRAP;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
